// File: rtl/vdp18_cpu_sched.sv
// +----------------------------------------------------------------------+
// | vdp18_cpu_sched : CPU data-port VRAM access scheduler (AC_CPU slots)  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package vdp18_pkg;
   typedef enum logic [2:0] {
      AC_NONE, AC_PNT, AC_PGT, AC_CT, AC_STST, AC_SATT, AC_SPT, AC_CPU
   } access_t;
endpackage

module vdp18_cpu_sched
   import vdp18_pkg::*;
#(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              clk_en_acc_i,
   input  access_t           access_type_i,
   input  logic              addr_load_i,
   input  logic              addr_rd_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              cpu_wr_i,
   input  logic              cpu_rd_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [DATA_W-1:0] vram_data_i,
   output logic [ADDR_W-1:0] vram_addr_o,
   output logic [DATA_W-1:0] vram_data_o,
   output logic              vram_we_o,
   output logic              cpu_grant_o,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              busy_o,
   output logic              overrun_o
);

   localparam logic [1:0] c_IDLE    = 2'd0;
   localparam logic [1:0] c_WR_PEND = 2'd1;
   localparam logic [1:0] c_RD_PEND = 2'd2;
   localparam logic [1:0] c_RD_CAPT = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, hold_addr_q, hold_addr_d;
   logic [DATA_W-1:0] wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d, hold_data_q, hold_data_d;
   logic              hold_ld_q, hold_ld_d, hold_ldrd_q, hold_ldrd_d;
   logic              hold_wr_q, hold_wr_d, hold_rd_q, hold_rd_d;

   logic              w_slot, w_pend, w_req_any, w_req_wr, w_req_rd;
   logic              w_apply, w_hold;
   logic              w_e_ld, w_e_ldrd, w_e_wr, w_e_rd;
   logic [ADDR_W-1:0] w_e_addr;
   logic [DATA_W-1:0] w_e_data;

   always_comb begin
      w_slot    = clk_en_acc_i & (access_type_i == AC_CPU);
      w_pend    = (state_q == c_WR_PEND) | (state_q == c_RD_PEND);
      w_req_any = addr_load_i | cpu_wr_i | cpu_rd_i;
      w_req_wr  = cpu_wr_i & ~addr_load_i;
      w_req_rd  = cpu_rd_i & ~addr_load_i & ~cpu_wr_i;
      // A fresh request wins over one held across the read-capture cycle.
      w_e_ld    = w_req_any ? addr_load_i : hold_ld_q;
      w_e_ldrd  = w_req_any ? addr_rd_i   : hold_ldrd_q;
      w_e_wr    = w_req_any ? w_req_wr    : hold_wr_q;
      w_e_rd    = w_req_any ? w_req_rd    : hold_rd_q;
      w_e_addr  = w_req_any ? addr_i      : hold_addr_q;
      w_e_data  = w_req_any ? wr_data_i   : hold_data_q;
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wr_buf_d    = wr_buf_q;
      rd_buf_d    = rd_buf_q;
      hold_ld_d   = hold_ld_q;
      hold_ldrd_d = hold_ldrd_q;
      hold_wr_d   = hold_wr_q;
      hold_rd_d   = hold_rd_q;
      hold_addr_d = hold_addr_q;
      hold_data_d = hold_data_q;
      w_apply     = 1'b0;
      w_hold      = 1'b0;
      case (state_q)
         c_WR_PEND: begin
            if (w_slot) begin
               rd_buf_d = wr_buf_q;
               addr_d   = addr_q + ADDR_W'(1);
               state_d  = c_IDLE;
            end
            w_apply = w_req_any;
         end
         c_RD_PEND: begin
            if (w_slot) begin
               state_d = c_RD_CAPT;
               w_hold  = w_req_any;
            end else begin
               w_apply = w_req_any;
            end
         end
         c_RD_CAPT: begin
            rd_buf_d = vram_data_i;
            addr_d   = addr_q + ADDR_W'(1);
            state_d  = c_IDLE;
            w_hold   = w_req_any;
         end
         default: begin
            w_apply   = 1'b1;
            hold_ld_d = 1'b0;
            hold_wr_d = 1'b0;
            hold_rd_d = 1'b0;
         end
      endcase
      if (w_hold) begin
         hold_ld_d   = addr_load_i;
         hold_ldrd_d = addr_rd_i;
         hold_wr_d   = w_req_wr;
         hold_rd_d   = w_req_rd;
         hold_addr_d = addr_i;
         hold_data_d = wr_data_i;
      end
      // Load supersedes the increment of a write granted in the same clock.
      if (w_apply) begin
         state_d = c_IDLE;
         if (w_e_ld) begin
            addr_d = w_e_addr;
            if (w_e_ldrd) state_d = c_RD_PEND;
         end else if (w_e_wr) begin
            wr_buf_d = w_e_data;
            state_d  = c_WR_PEND;
         end else if (w_e_rd) begin
            state_d = c_RD_PEND;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= c_IDLE;
         addr_q      <= '0;
         wr_buf_q    <= '0;
         rd_buf_q    <= '0;
         hold_ld_q   <= 1'b0;
         hold_ldrd_q <= 1'b0;
         hold_wr_q   <= 1'b0;
         hold_rd_q   <= 1'b0;
         hold_addr_q <= '0;
         hold_data_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wr_buf_q    <= wr_buf_d;
         rd_buf_q    <= rd_buf_d;
         hold_ld_q   <= hold_ld_d;
         hold_ldrd_q <= hold_ldrd_d;
         hold_wr_q   <= hold_wr_d;
         hold_rd_q   <= hold_rd_d;
         hold_addr_q <= hold_addr_d;
         hold_data_q <= hold_data_d;
      end
   end

   assign vram_addr_o = addr_q;
   assign vram_data_o = wr_buf_q;
   assign rd_data_o   = rd_buf_q;
   assign vram_we_o   = w_slot & (state_q == c_WR_PEND);
   assign cpu_grant_o = w_slot & w_pend;
   assign busy_o      = (state_q != c_IDLE);
   assign overrun_o   = w_pend & ~w_slot & w_req_any;

endmodule

`default_nettype wire

// File: tb/tb_vdp18_cpu_sched.sv
// Bench for vdp18_cpu_sched: directed vector table, corner sequences, random vs model.
`default_nettype none

module tb_vdp18_cpu_sched;
   import vdp18_pkg::*;

   localparam int AW   = 14;
   localparam int DW   = 8;
   localparam int AMOD = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   access_t       atype;
   logic          ld, ldrd, wr, rd;
   logic [AW-1:0] ain;
   logic [DW-1:0] wd, vd;
   logic [AW-1:0] o_va;
   logic [DW-1:0] o_vdat, o_rdat;
   logic          o_we, o_gnt, o_busy, o_ovr;

   always #5 clk = ~clk;

   vdp18_cpu_sched #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_i(clk), .reset_n_i(rst_n), .clk_en_acc_i(en), .access_type_i(atype),
      .addr_load_i(ld), .addr_rd_i(ldrd), .addr_i(ain), .cpu_wr_i(wr), .cpu_rd_i(rd),
      .wr_data_i(wd), .vram_data_i(vd), .vram_addr_o(o_va), .vram_data_o(o_vdat),
      .vram_we_o(o_we), .cpu_grant_o(o_gnt), .rd_data_o(o_rdat), .busy_o(o_busy),
      .overrun_o(o_ovr)
   );

   int checks = 0;
   int errors = 0;

   function automatic void check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // ---------------- reference model ----------------
   typedef struct { bit ld; bit ldrd; bit wr; bit rd; int a; int d; } req_t;
   localparam int M_IDLE = 0, M_WAIT_WR = 1, M_WAIT_RD = 2, M_RETURN = 3;
   int   m_mode, m_addr, m_wbuf, m_rbuf;
   req_t m_hold[$];

   function automatic void model_reset();
      m_mode = M_IDLE; m_addr = 0; m_wbuf = 0; m_rbuf = 0;
      m_hold.delete();
   endfunction

   function automatic bit has_req();
      return ld | wr | rd;
   endfunction

   function automatic bit cpu_slot();
      return en && (atype == AC_CPU);
   endfunction

   function automatic req_t fresh_req();
      req_t r = '{default: 0};
      if (ld) begin r.ld = 1; r.ldrd = ldrd; r.a = int'(ain); end
      else if (wr) begin r.wr = 1; r.d = int'(wd); end
      else if (rd) r.rd = 1;
      return r;
   endfunction

   function automatic void model_apply(req_t r);
      m_mode = M_IDLE;
      if (r.ld) begin
         m_addr = r.a;
         if (r.ldrd) m_mode = M_WAIT_RD;
      end else if (r.wr) begin
         m_wbuf = r.d; m_mode = M_WAIT_WR;
      end else if (r.rd) m_mode = M_WAIT_RD;
   endfunction

   function automatic void model_step();
      req_t f = fresh_req();
      bit   hf = has_req();
      bit   s  = cpu_slot();
      case (m_mode)
         M_RETURN: begin
            m_rbuf = int'(vd); m_addr = (m_addr + 1) % AMOD; m_mode = M_IDLE;
            if (hf) begin m_hold.delete(); m_hold.push_back(f); end
         end
         M_WAIT_RD: begin
            if (s) begin
               m_mode = M_RETURN;
               if (hf) begin m_hold.delete(); m_hold.push_back(f); end
            end else if (hf) model_apply(f);
         end
         M_WAIT_WR: begin
            if (s) begin m_rbuf = m_wbuf; m_addr = (m_addr + 1) % AMOD; m_mode = M_IDLE; end
            if (hf) model_apply(f);
         end
         default: begin
            if (hf) model_apply(f);
            else if (m_hold.size() > 0) model_apply(m_hold[0]);
            m_hold.delete();
         end
      endcase
   endfunction

   function automatic void check_model(string tag);
      bit s = cpu_slot();
      bit pend = (m_mode == M_WAIT_WR) || (m_mode == M_WAIT_RD);
      check({tag, "_we"},   int'(o_we),   int'((m_mode == M_WAIT_WR) && s));
      check({tag, "_gnt"},  int'(o_gnt),  int'(pend && s));
      check({tag, "_busy"}, int'(o_busy), int'(m_mode != M_IDLE));
      check({tag, "_ovr"},  int'(o_ovr),  int'(pend && !s && has_req()));
      check({tag, "_va"},   int'(o_va),   m_addr);
      check({tag, "_vdat"}, int'(o_vdat), m_wbuf);
      check({tag, "_rdat"}, int'(o_rdat), m_rbuf);
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic set_idle();
      en = 0; atype = AC_NONE; ld = 0; ldrd = 0; ain = '0;
      wr = 0; rd = 0; wd = '0; vd = '0;
   endtask

   task automatic set_slot(int k);
      en    = (k != 0);
      atype = (k == 2) ? AC_PNT : AC_CPU;
   endtask

   // Inputs are set at a negedge; check 1ns later, then advance to next negedge.
   task automatic cyc(string tag);
      #1;
      check_model(tag);
      model_step();
      @(posedge clk);
      @(negedge clk);
      set_idle();
   endtask

   typedef struct {
      bit ld; bit ldrd; logic [AW-1:0] a; bit wr; logic [DW-1:0] wd; bit rd; int slot; logic [DW-1:0] vd;
      bit we; bit gnt; bit busy; bit ovr; logic [AW-1:0] va; logic [DW-1:0] vdat; logic [DW-1:0] rdat;
   } vec_t;
   vec_t tbl[$];

   int we_cnt;
   bit ovr_seen;

   initial begin
      // ld ldrd addr wr wd rd slot vd | we gnt busy ovr va vdat rdat
      tbl.push_back(vec_t'{1,0,14'h1000,0,8'h00,0,0,8'h00, 0,0,0,0,14'h0000,8'h00,8'h00});
      tbl.push_back(vec_t'{0,0,14'h0000,1,8'hA5,0,0,8'h00, 0,0,0,0,14'h1000,8'h00,8'h00});
      tbl.push_back(vec_t'{0,0,14'h0000,0,8'h00,0,2,8'h00, 0,0,1,0,14'h1000,8'hA5,8'h00});
      tbl.push_back(vec_t'{0,0,14'h0000,0,8'h00,0,0,8'h00, 0,0,1,0,14'h1000,8'hA5,8'h00});
      tbl.push_back(vec_t'{0,0,14'h0000,0,8'h00,0,1,8'h00, 1,1,1,0,14'h1000,8'hA5,8'h00});
      tbl.push_back(vec_t'{0,0,14'h0000,0,8'h00,0,0,8'h00, 0,0,0,0,14'h1001,8'hA5,8'hA5});
      tbl.push_back(vec_t'{1,1,14'h3FFF,0,8'h00,0,0,8'h00, 0,0,0,0,14'h1001,8'hA5,8'hA5});
      tbl.push_back(vec_t'{0,0,14'h0000,0,8'h00,0,1,8'h00, 0,1,1,0,14'h3FFF,8'hA5,8'hA5});
      tbl.push_back(vec_t'{0,0,14'h0000,0,8'h00,0,0,8'h5A, 0,0,1,0,14'h3FFF,8'hA5,8'hA5});
      tbl.push_back(vec_t'{0,0,14'h0000,0,8'h00,1,0,8'h00, 0,0,0,0,14'h0000,8'hA5,8'h5A});
      tbl.push_back(vec_t'{0,0,14'h0000,0,8'h00,0,1,8'h00, 0,1,1,0,14'h0000,8'hA5,8'h5A});
      tbl.push_back(vec_t'{0,0,14'h0000,0,8'h00,0,0,8'hC3, 0,0,1,0,14'h0000,8'hA5,8'h5A});
      tbl.push_back(vec_t'{0,0,14'h0000,1,8'h11,0,0,8'h00, 0,0,0,0,14'h0001,8'hA5,8'hC3});
      tbl.push_back(vec_t'{0,0,14'h0000,1,8'h22,0,0,8'h00, 0,0,1,1,14'h0001,8'h11,8'hC3});
      tbl.push_back(vec_t'{0,0,14'h0000,0,8'h00,0,1,8'h00, 1,1,1,0,14'h0001,8'h22,8'hC3});
      tbl.push_back(vec_t'{0,0,14'h0000,0,8'h00,0,0,8'h00, 0,0,0,0,14'h0002,8'h22,8'h22});

      // Reset state
      rst_n = 1'b0;
      set_idle();
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_we", int'(o_we), 0);
      check("rst_gnt", int'(o_gnt), 0);
      check("rst_busy", int'(o_busy), 0);
      check("rst_ovr", int'(o_ovr), 0);
      check("rst_va", int'(o_va), 0);
      check("rst_vdat", int'(o_vdat), 0);
      check("rst_rdat", int'(o_rdat), 0);
      rst_n = 1'b1;

      // Directed vector table
      for (int i = 0; i < tbl.size(); i++) begin
         ld = tbl[i].ld; ldrd = tbl[i].ldrd; ain = tbl[i].a; wr = tbl[i].wr; wd = tbl[i].wd;
         rd = tbl[i].rd; vd = tbl[i].vd; set_slot(tbl[i].slot);
         #1;
         check($sformatf("v%0d_we", i),   int'(o_we),   int'(tbl[i].we));
         check($sformatf("v%0d_gnt", i),  int'(o_gnt),  int'(tbl[i].gnt));
         check($sformatf("v%0d_busy", i), int'(o_busy), int'(tbl[i].busy));
         check($sformatf("v%0d_ovr", i),  int'(o_ovr),  int'(tbl[i].ovr));
         check($sformatf("v%0d_va", i),   int'(o_va),   int'(tbl[i].va));
         check($sformatf("v%0d_vdat", i), int'(o_vdat), int'(tbl[i].vdat));
         check($sformatf("v%0d_rdat", i), int'(o_rdat), int'(tbl[i].rdat));
         model_step();
         @(posedge clk);
         @(negedge clk);
         set_idle();
      end

      // Request coincident with a slot while idle: granted only at the next slot
      wr = 1; wd = 8'h77; set_slot(1);
      #1 check("idle_slot_nogrant", int'(o_gnt), 0);
      #0 cyc("c4a");
      set_slot(1);
      #1 check("idle_slot_next_we", int'(o_we), 1);
      check("idle_slot_next_data", int'(o_vdat), 8'h77);
      #0 cyc("c4b");

      // Address load during a pending write cancels it
      ld = 1; ain = 14'h0300; cyc("c5a");
      wr = 1; wd = 8'h44; cyc("c5b");
      ld = 1; ain = 14'h0200;
      #1 check("cancel_ovr", int'(o_ovr), 1);
      #0 cyc("c5c");
      we_cnt = 0;
      for (int k = 0; k < 3; k++) begin
         set_slot(1);
         #1 we_cnt += int'(o_we);
         #0 cyc("c5d");
      end
      check("cancel_no_we", we_cnt, 0);
      check("cancel_addr", int'(o_va), 14'h0200);

      // Write request held across the read-capture clock
      ld = 1; ldrd = 1; ain = 14'h0020; cyc("hld_a");
      set_slot(1); cyc("hld_b");
      wr = 1; wd = 8'h66; vd = 8'h12;
      #1 check("hold_no_ovr", int'(o_ovr), 0);
      #0 cyc("hld_c");
      cyc("hld_d");
      set_slot(1);
      #1 check("hold_we", int'(o_we), 1);
      check("hold_va", int'(o_va), 14'h0021);
      check("hold_vdat", int'(o_vdat), 8'h66);
      check("hold_rdat", int'(o_rdat), 8'h12);
      #0 cyc("hld_e");

      // Asynchronous reset in the read-capture clock
      ld = 1; ldrd = 1; ain = 14'h0010; cyc("r6a");
      set_slot(1); cyc("r6b");
      vd = 8'h99; set_slot(1);
      rst_n = 1'b0;
      #1 check("arst_busy", int'(o_busy), 0);
      check("arst_we", int'(o_we), 0);
      check("arst_gnt", int'(o_gnt), 0);
      check("arst_va", int'(o_va), 0);
      check("arst_rdat", int'(o_rdat), 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      set_idle();
      rst_n = 1'b1;
      cyc("r6c");
      check("arst_rdat_after", int'(o_rdat), 0);

      // Randomized traffic against the model
      ovr_seen = 0;
      for (int n = 0; n < 800; n++) begin
         ld   = ($urandom_range(0, 11) == 0);
         ldrd = $urandom_range(0, 1);
         ain  = AW'($urandom_range(0, AMOD - 1));
         if (($urandom_range(0, 7) == 0)) ain = AW'(AMOD - 1);
         wr   = ($urandom_range(0, 5) == 0);
         rd   = ($urandom_range(0, 5) == 0);
         wd   = DW'($urandom);
         vd   = DW'($urandom);
         en   = ($urandom_range(0, 2) == 0);
         atype = ($urandom_range(0, 1) == 0) ? AC_CPU : access_t'($urandom_range(0, 7));
         #1 ovr_seen |= o_ovr;
         #0 cyc($sformatf("r%0d", n));
      end
      check("rand_overrun_exercised", int'(ovr_seen), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
